popcount_frame_accumulator: RTL

- Sits directly downstream of the combinational 16-bit ones-counter.
- Consumes its 5-bit per-word ones counts over a valid/ready handshake and accumulates them across a frame of words.
- Reports the frame total, word count, per-word maximum and error/overflow flags on a held output with its own valid/ready handshake.

---
 rtl/popcount_frame_accumulator_if.sv | 39 +++
 rtl/popcount_frame_accumulator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/popcount_frame_accumulator_if.sv
// Word-count input stream and frame-result output stream of popcount_frame_accumulator.
// out_hits exists only when POPACC_THRESH_HITS_EN is defined.
interface popcount_frame_accumulator_if #(
    parameter int TOTAL_W = 9,
    parameter int WCNT_W  = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_count;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [TOTAL_W-1:0] out_total;
    logic [WCNT_W-1:0]  out_words;
    logic [4:0]         out_max;
    logic               out_ovf;
    logic               out_err;
`ifdef POPACC_THRESH_HITS_EN
    logic [WCNT_W-1:0]  out_hits;
`endif

    // Accumulator side: sinks word counts, sources frame results.
    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_total, out_words, out_max, out_ovf, out_err
`ifdef POPACC_THRESH_HITS_EN
        , output out_hits
`endif
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_total, out_words, out_max, out_ovf, out_err
`ifdef POPACC_THRESH_HITS_EN
        , input out_hits
`endif
    );
endinterface

// File: rtl/popcount_frame_accumulator.sv
// Accumulates 5-bit per-word ones counts into frame total/words/max/err/ovf (optional hits via POPACC_THRESH_HITS_EN).
// Latency: result valid the cycle after the closing beat; held in HOLD until consumed.
// Backpressure: in_ready drops while a result is held, giving a one-cycle bubble between frames.
module popcount_frame_accumulator #(
    parameter int TOTAL_W   = 9,
    parameter int FRAME_MAX = 16,
    parameter int WCNT_W    = 5,
    parameter int THRESH    = 8
) (
    input  logic clk,
    input  logic rst_n,
    popcount_frame_accumulator_if.slave bus
);

    if (FRAME_MAX < 1 || (1 << WCNT_W) <= FRAME_MAX || TOTAL_W < 5 || THRESH < 0 || THRESH > 16) begin : g_bad_params
        $error("popcount_frame_accumulator: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [TOTAL_W-1:0] acc_total;
    logic [WCNT_W-1:0]  acc_words;
    logic [4:0]         acc_max;
    logic               acc_ovf;
    logic               acc_err;

    logic [TOTAL_W-1:0] out_total_q;
    logic [WCNT_W-1:0]  out_words_q;
    logic [4:0]         out_max_q;
    logic               out_ovf_q;
    logic               out_err_q;

    logic               accept;
    logic               first;
    logic               over;
    logic [4:0]         c;
    logic [TOTAL_W-1:0] base_total;
    logic [TOTAL_W:0]   sum;
    logic [TOTAL_W-1:0] nxt_total;
    logic               nxt_ovf;
    logic [WCNT_W-1:0]  nxt_words;
    logic [4:0]         nxt_max;
    logic               nxt_err;
    logic               close;

`ifdef POPACC_THRESH_HITS_EN
    logic [WCNT_W-1:0]  acc_hits;
    logic [WCNT_W-1:0]  out_hits_q;
    logic [WCNT_W-1:0]  base_hits;
    logic [WCNT_W-1:0]  nxt_hits;
`endif

    always_comb begin
        accept     = bus.in_valid && in_ready_q;
        first      = (state == IDLE);
        over       = (bus.in_count > 5'd16);
        c          = over ? 5'd16 : bus.in_count;
        base_total = first ? '0 : acc_total;
        sum        = {1'b0, base_total} + (TOTAL_W+1)'(c);
        // Once saturated, the frame total stays pinned even if later adds do not carry.
        if (sum[TOTAL_W] || (!first && acc_ovf)) begin
            nxt_total = '1;
            nxt_ovf   = 1'b1;
        end else begin
            nxt_total = sum[TOTAL_W-1:0];
            nxt_ovf   = 1'b0;
        end
        nxt_words = first ? WCNT_W'(1) : acc_words + WCNT_W'(1);
        nxt_max   = (first || c > acc_max) ? c : acc_max;
        nxt_err   = (!first && acc_err) || over;
        close     = bus.in_last || (nxt_words == WCNT_W'(FRAME_MAX));
`ifdef POPACC_THRESH_HITS_EN
        base_hits = first ? '0 : acc_hits;
        nxt_hits  = base_hits;
        if (c >= 5'(THRESH) && base_hits != WCNT_W'(FRAME_MAX))
            nxt_hits = base_hits + WCNT_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_total   <= '0;
            acc_words   <= '0;
            acc_max     <= '0;
            acc_ovf     <= 1'b0;
            acc_err     <= 1'b0;
            out_total_q <= '0;
            out_words_q <= '0;
            out_max_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef POPACC_THRESH_HITS_EN
            acc_hits    <= '0;
            out_hits_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_total <= nxt_total;
                        acc_words <= nxt_words;
                        acc_max   <= nxt_max;
                        acc_ovf   <= nxt_ovf;
                        acc_err   <= nxt_err;
`ifdef POPACC_THRESH_HITS_EN
                        acc_hits  <= nxt_hits;
`endif
                        if (close) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_total_q <= nxt_total;
                            out_words_q <= nxt_words;
                            out_max_q   <= nxt_max;
                            out_ovf_q   <= nxt_ovf;
                            out_err_q   <= nxt_err;
`ifdef POPACC_THRESH_HITS_EN
                            out_hits_q  <= nxt_hits;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_total = out_total_q;
    assign bus.out_words = out_words_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_err   = out_err_q;
`ifdef POPACC_THRESH_HITS_EN
    assign bus.out_hits  = out_hits_q;
`endif

endmodule
